// File: rtl/lightshow_sequencer.sv
// AXI4-Lite write-only master that replays a programmable (address, data) table
// as frames of single-beat writes, optionally looping with an idle gap.
module lightshow_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TABLE_DEPTH  = 16,
    parameter int PERIOD_WIDTH = 32,
    localparam int IW          = $clog2(TABLE_DEPTH),
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_tbl_we,
    input  logic [IW-1:0]           i_tbl_idx,
    input  logic [ADDR_WIDTH-1:0]   i_tbl_addr,
    input  logic [DATA_WIDTH-1:0]   i_tbl_data,
    input  logic [IW:0]             i_count,
    input  logic [PERIOD_WIDTH-1:0] i_frame_period,
    input  logic                    i_loop,
    input  logic                    i_start,
    input  logic                    i_stop,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_error,
    output logic [15:0]             o_frame_count,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STRB_W-1:0]       o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    input  logic [1:0]              i_bresp,
    output logic                    o_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_FRAME_END,
        S_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_tbl_addr [TABLE_DEPTH];
    logic [DATA_WIDTH-1:0]   r_tbl_data [TABLE_DEPTH];

    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           w_next_idx;
    logic [IW:0]             r_count;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_wait_cnt;
    logic                    r_loop;
    logic                    r_stop;
    logic                    r_error;
    logic [15:0]             r_frame_count;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_stop_req;
    logic                    w_aw_ok;
    logic                    w_w_ok;
    logic                    w_last;
    logic                    w_issue_enter;
    logic                    w_start;

    // Table has no reset; an entry is read at the moment its write is issued.
    always_ff @(posedge i_axi_clk) begin
        if (i_tbl_we) begin
            r_tbl_addr[i_tbl_idx] <= i_tbl_addr;
            r_tbl_data[i_tbl_idx] <= i_tbl_data;
        end
    end

    assign w_start    = (r_state == S_IDLE) && i_start;
    assign w_stop_req = r_stop || i_stop;
    assign w_aw_ok    = !r_awvalid || i_awready;
    assign w_w_ok     = !r_wvalid || i_wready;
    assign w_last     = (({1'b0, r_idx} + (IW+1)'(1)) >= r_count);

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_idx = '0;
                    w_next     = (i_count == '0) ? S_FRAME_END : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_aw_ok && w_w_ok)
                    w_next = S_RESP;
            end
            S_RESP: begin
                if (i_bvalid) begin
                    if (w_stop_req) begin
                        w_next = S_IDLE;
                    end else if (!w_last) begin
                        w_next     = S_ISSUE;
                        w_next_idx = r_idx + IW'(1);
                    end else begin
                        w_next = S_FRAME_END;
                    end
                end
            end
            S_FRAME_END: begin
                if (r_loop && !w_stop_req) begin
                    w_next_idx = '0;
                    if (r_period != '0)
                        w_next = S_WAIT;
                    else
                        w_next = (r_count == '0) ? S_FRAME_END : S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_stop_req) begin
                    w_next = S_IDLE;
                end else if (r_wait_cnt == '0) begin
                    w_next_idx = '0;
                    w_next     = (r_count == '0) ? S_FRAME_END : S_ISSUE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_issue_enter = (w_next == S_ISSUE) && (r_state != S_ISSUE);

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_count       <= '0;
            r_period      <= '0;
            r_wait_cnt    <= '0;
            r_loop        <= 1'b0;
            r_stop        <= 1'b0;
            r_error       <= 1'b0;
            r_frame_count <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_awaddr      <= '0;
            r_wdata       <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_next_idx;

            if (w_start) begin
                r_count  <= i_count;
                r_period <= i_frame_period;
                r_loop   <= i_loop;
            end

            // Stop request lives until IDLE is reached; ignored while idle.
            if (w_next == S_IDLE)
                r_stop <= 1'b0;
            else if (i_stop && r_state != S_IDLE)
                r_stop <= 1'b1;

            if (w_start)
                r_error <= 1'b0;
            else if (r_state == S_RESP && i_bvalid && i_bresp != 2'b00)
                r_error <= 1'b1;

            if (w_start)
                r_frame_count <= '0;
            else if (r_state == S_FRAME_END)
                r_frame_count <= r_frame_count + 16'd1;

            // Loaded with period-1 so WAIT lasts exactly period cycles.
            if (r_state == S_FRAME_END)
                r_wait_cnt <= r_period - PERIOD_WIDTH'(1);
            else if (r_state == S_WAIT && r_wait_cnt != '0)
                r_wait_cnt <= r_wait_cnt - PERIOD_WIDTH'(1);

            if (w_issue_enter) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= r_tbl_addr[w_next_idx];
                r_wdata   <= r_tbl_data[w_next_idx];
            end else begin
                if (r_awvalid && i_awready)
                    r_awvalid <= 1'b0;
                if (r_wvalid && i_wready)
                    r_wvalid <= 1'b0;
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = (r_state == S_FRAME_END);
    assign o_bready      = (r_state == S_RESP);
    assign o_error       = r_error;
    assign o_frame_count = r_frame_count;
    assign o_awvalid     = r_awvalid;
    assign o_awaddr      = r_awaddr;
    assign o_wvalid      = r_wvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = '1;

endmodule

// File: tb/tb_lightshow_sequencer.sv
// Directed + randomized bench for lightshow_sequencer with an in-bench AXI slave
// and a table-level reference model of the expected write stream.
module tb_lightshow_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TD = 16;
    localparam int PW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          i_axi_rst;
    logic          i_tbl_we;
    logic [IW-1:0] i_tbl_idx;
    logic [AW-1:0] i_tbl_addr;
    logic [DW-1:0] i_tbl_data;
    logic [IW:0]   i_count;
    logic [PW-1:0] i_frame_period;
    logic          i_loop, i_start, i_stop;
    logic          o_busy, o_frame_done, o_error;
    logic [15:0]   o_frame_count;
    logic          o_awvalid, i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid, i_wready;
    logic [DW-1:0] o_wdata;
    logic [3:0]    o_wstrb;
    logic          i_bvalid, o_bready;
    logic [1:0]    i_bresp;

    lightshow_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TABLE_DEPTH(TD), .PERIOD_WIDTH(PW)) dut (
        .i_axi_clk(clk), .i_axi_rst(i_axi_rst),
        .i_tbl_we(i_tbl_we), .i_tbl_idx(i_tbl_idx), .i_tbl_addr(i_tbl_addr), .i_tbl_data(i_tbl_data),
        .i_count(i_count), .i_frame_period(i_frame_period), .i_loop(i_loop),
        .i_start(i_start), .i_stop(i_stop),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error), .o_frame_count(o_frame_count),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference table and expected write stream
    logic [AW-1:0] m_addr [TD];
    logic [DW-1:0] m_data [TD];
    logic [AW-1:0] exp_a [$];
    logic [DW-1:0] exp_d [$];

    // slave model state and observed traffic
    logic [AW-1:0] q_aw [$];
    logic [DW-1:0] q_w  [$];
    logic [1:0]    q_resp [$];
    int n_b = 0, n_done = 0;
    int aw_min = 0, aw_max = 0, w_min = 0, w_max = 0, b_min = 1, b_max = 1;
    int aw_cnt = -1, w_cnt = -1, b_cnt = -1;
    logic aw_pend = 1'b0, w_pend = 1'b0;
    logic [AW-1:0] aw_prev;
    logic [DW-1:0] w_prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (i_axi_rst) begin
            i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
            aw_cnt = -1; w_cnt = -1; b_cnt = -1; aw_pend = 1'b0; w_pend = 1'b0;
        end else begin
            if (aw_pend) begin
                check("aw_hold_valid", o_awvalid, 1'b1);
                check("aw_hold_addr", o_awaddr, aw_prev);
            end
            if (w_pend) begin
                check("w_hold_valid", o_wvalid, 1'b1);
                check("w_hold_data", o_wdata, w_prev);
            end
            if (o_frame_done) n_done++;
            i_awready = 1'b0;
            if (o_awvalid) begin
                if (aw_cnt < 0) aw_cnt = $urandom_range(aw_max, aw_min);
                if (aw_cnt == 0) begin
                    i_awready = 1'b1; q_aw.push_back(o_awaddr); aw_cnt = -1;
                end else aw_cnt--;
            end
            aw_pend = o_awvalid && !i_awready; aw_prev = o_awaddr;
            i_wready = 1'b0;
            if (o_wvalid) begin
                if (w_cnt < 0) w_cnt = $urandom_range(w_max, w_min);
                if (w_cnt == 0) begin
                    i_wready = 1'b1; q_w.push_back(o_wdata); w_cnt = -1;
                end else w_cnt--;
            end
            w_pend = o_wvalid && !i_wready; w_prev = o_wdata;
            i_bvalid = 1'b0; i_bresp = 2'b00;
            if (o_bready) begin
                if (b_cnt < 0) b_cnt = $urandom_range(b_max, b_min);
                if (b_cnt == 0) begin
                    i_bvalid = 1'b1;
                    i_bresp = (q_resp.size() > 0) ? q_resp.pop_front() : 2'b00;
                    n_b++; b_cnt = -1;
                end else b_cnt--;
            end
        end
    endtask

    task automatic tbl_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_tbl_we = 1'b1; i_tbl_idx = idx[IW-1:0]; i_tbl_addr = a; i_tbl_data = d;
        step();
        i_tbl_we = 1'b0;
        m_addr[idx] = a; m_data[idx] = d;
    endtask

    task automatic clear_obs();
        q_aw.delete(); q_w.delete(); q_resp.delete(); exp_a.delete(); exp_d.delete();
        n_b = 0; n_done = 0;
    endtask

    task automatic build_frame(input int n);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(m_addr[i]); exp_d.push_back(m_data[i]);
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_aw_n"}, q_aw.size(), exp_a.size());
        check({tag, "_w_n"}, q_w.size(), exp_d.size());
        check({tag, "_b_n"}, n_b, exp_a.size());
        for (int i = 0; i < exp_a.size() && i < q_aw.size(); i++) check({tag, "_awaddr"}, q_aw[i], exp_a[i]);
        for (int i = 0; i < exp_d.size() && i < q_w.size(); i++) check({tag, "_wdata"}, q_w[i], exp_d[i]);
    endtask

    task automatic start_run(input int cnt, input int period, input logic loop);
        i_count = cnt[IW:0]; i_frame_period = period; i_loop = loop; i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic run_to_idle(input int max);
        int n = 0;
        while (o_busy && n < max) begin step(); n++; end
        check("idle_timeout", o_busy, 1'b0);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!o_frame_done && n < max) begin step(); n++; end
        check("done_timeout", o_frame_done, 1'b1);
    endtask

    task automatic wait_awvalid(input int max);
        int n = 0;
        while (!o_awvalid && n < max) begin step(); n++; end
        check("awvalid_timeout", o_awvalid, 1'b1);
    endtask

    initial begin
        int busy_cycles, t_done, cnt, n;
        logic exp_err;
        i_axi_rst = 1'b1; i_tbl_we = 1'b0; i_tbl_idx = '0; i_tbl_addr = '0; i_tbl_data = '0;
        i_count = '0; i_frame_period = '0; i_loop = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
        repeat (3) step();
        i_axi_rst = 1'b0;
        step();

        // reset state
        check("rst_busy", o_busy, 1'b0);
        check("rst_awvalid", o_awvalid, 1'b0);
        check("rst_wvalid", o_wvalid, 1'b0);
        check("rst_bready", o_bready, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_fcount", o_frame_count, 16'd0);
        check("rst_awaddr", o_awaddr, 32'd0);
        check("rst_wdata", o_wdata, 32'd0);
        check("rst_wstrb", o_wstrb, 4'hF);

        // basic 3-entry frame, always-ready slave, B one cycle after bready
        tbl_write(0, 32'h00, 32'h1); tbl_write(1, 32'h04, 32'h2); tbl_write(2, 32'h08, 32'h3);
        clear_obs();
        start_run(3, 0, 1'b0);
        check("start_awvalid", o_awvalid, 1'b1);
        check("start_wvalid", o_wvalid, 1'b1);
        busy_cycles = 0; n = 0;
        while (o_busy && n < 200) begin busy_cycles++; step(); n++; end
        check("basic_busy_cycles", busy_cycles, 10);
        build_frame(3);
        compare_writes("basic");
        check("basic_done_n", n_done, 1);
        check("basic_fcount", o_frame_count, 16'd1);
        check("basic_busy", o_busy, 1'b0);
        check("basic_error", o_error, 1'b0);

        // stalled slave: AW late then W late
        for (int pass = 0; pass < 2; pass++) begin
            aw_min = (pass == 0) ? 4 : 0; aw_max = aw_min;
            w_min = (pass == 0) ? 0 : 4;  w_max = w_min;
            clear_obs();
            start_run(3, 0, 1'b0);
            run_to_idle(200);
            build_frame(3);
            compare_writes("stall");
            check("stall_done_n", n_done, 1);
        end

        // randomized tables, counts, slave delays and responses
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < TD; i++) tbl_write(i, $urandom, $urandom);
            cnt = (it == 0) ? TD : $urandom_range(TD, 1);
            aw_min = 0; aw_max = 3; w_min = 0; w_max = 3; b_min = 0; b_max = 3;
            clear_obs();
            exp_err = 1'b0;
            for (int i = 0; i < cnt; i++) begin
                q_resp.push_back(($urandom_range(3, 0) == 0) ? 2'b10 : 2'b00);
                if (q_resp[i] != 2'b00) exp_err = 1'b1;
            end
            start_run(cnt, 0, 1'b0);
            run_to_idle(2000);
            build_frame(cnt);
            compare_writes("rand");
            check("rand_error", o_error, exp_err);
            check("rand_fcount", o_frame_count, 16'd1);
        end
        aw_min = 0; aw_max = 0; w_min = 0; w_max = 0; b_min = 1; b_max = 1;

        // loop, period 5: gap check, then stop during RESP of entry 1
        tbl_write(0, 32'h00, 32'h1); tbl_write(1, 32'h04, 32'h2); tbl_write(2, 32'h08, 32'h3);
        clear_obs();
        start_run(3, 5, 1'b1);
        wait_done(100);
        t_done = cyc;
        wait_awvalid(100);
        check("gap_p5", cyc - t_done, 6);
        n = 0;
        while (!(o_bready && q_aw.size() == 5) && n < 100) begin step(); n++; end
        check("resp1_timeout", o_bready, 1'b1);
        i_stop = 1'b1; step(); i_stop = 1'b0;
        run_to_idle(100);
        build_frame(3); build_frame(2);
        compare_writes("stop_resp");
        check("stop_resp_done_n", n_done, 1);
        check("stop_resp_fcount", o_frame_count, 16'd1);

        // loop, period 0: one-cycle gap, stop during ISSUE
        clear_obs();
        start_run(2, 0, 1'b1);
        wait_done(100);
        t_done = cyc;
        wait_awvalid(100);
        check("gap_p0", cyc - t_done, 1);
        i_stop = 1'b1; step(); i_stop = 1'b0;
        run_to_idle(100);
        build_frame(2); build_frame(1);
        compare_writes("stop_issue");
        check("stop_issue_done_n", n_done, 1);

        // error response on entry 0, then cleared by next start
        clear_obs();
        q_resp.push_back(2'b10);
        start_run(3, 0, 1'b0);
        n = 0;
        while (n_b < 1 && n < 50) begin step(); n++; end
        step();
        check("err_set", o_error, 1'b1);
        run_to_idle(100);
        build_frame(3);
        compare_writes("err");
        check("err_sticky", o_error, 1'b1);
        clear_obs();
        start_run(3, 0, 1'b0);
        check("err_cleared", o_error, 1'b0);
        run_to_idle(100);
        check("err_still_clear", o_error, 1'b0);

        // count 0, loop, period 0: frame_done every cycle, frame_count wraps
        clear_obs();
        start_run(0, 0, 1'b1);
        check("c0_done_first", o_frame_done, 1'b1);
        check("c0_fcount_first", o_frame_count, 16'd0);
        for (int j = 1; j <= 65538; j++) begin
            step();
            if (j == 65535) check("c0_fcount_ffff", o_frame_count, 16'hFFFF);
            if (j == 65536) check("c0_fcount_wrap", o_frame_count, 16'h0000);
        end
        check("c0_fcount_end", o_frame_count, 16'd2);
        check("c0_done_n", n_done, 65539);
        check("c0_no_aw", q_aw.size(), 0);
        check("c0_no_w", q_w.size(), 0);
        i_stop = 1'b1; step(); i_stop = 1'b0;
        check("c0_stopped", o_busy, 1'b0);

        // asynchronous reset while AW is stalled on entry 1
        tbl_write(0, 32'h100, 32'hA5); tbl_write(1, 32'h104, 32'h5A);
        clear_obs();
        q_resp.push_back(2'b10);
        start_run(2, 0, 1'b0);
        n = 0;
        while (n_b < 1 && n < 50) begin step(); n++; end
        aw_min = 10; aw_max = 10;
        step(); step();
        check("pre_rst_awvalid", o_awvalid, 1'b1);
        check("pre_rst_awaddr", o_awaddr, 32'h104);
        check("pre_rst_error", o_error, 1'b1);
        #1 i_axi_rst = 1'b1;
        #1;
        check("arst_awvalid", o_awvalid, 1'b0);
        check("arst_wvalid", o_wvalid, 1'b0);
        check("arst_busy", o_busy, 1'b0);
        check("arst_bready", o_bready, 1'b0);
        check("arst_error", o_error, 1'b0);
        check("arst_fcount", o_frame_count, 16'd0);
        check("arst_awaddr", o_awaddr, 32'd0);
        check("arst_wdata", o_wdata, 32'd0);
        check("arst_wstrb", o_wstrb, 4'hF);
        step(); step();
        i_axi_rst = 1'b0;
        aw_min = 0; aw_max = 0;
        step();
        check("post_rst_busy", o_busy, 1'b0);
        check("post_rst_awvalid", o_awvalid, 1'b0);
        clear_obs();
        start_run(2, 0, 1'b0);
        run_to_idle(100);
        build_frame(2);
        compare_writes("post_rst");
        check("post_rst_fcount", o_frame_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
